// File: rtl/ahb_slave_ctrl.sv
// rtl/ahb_slave_ctrl.sv - AHB slave data-phase controller with write-data FIFO and core read handshake
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   HSELx, HTRANS            bus select and transfer type (HTRANS[1] = NONSEQ/SEQ)
//   addr_match, m_write,
//   m_read, data_ready,
//   invalid                  decoded address-phase flags from the upstream sensor
//   HWDATA                   write data in the data phase
//   HRDATA, HREADYOUT, HRESP data-phase response to the bus
//   wr_data, wr_valid,
//   wr_ready                 write-data FIFO head toward the core
//   rd_req, rd_data,
//   rd_valid                 read request pulse and returned core data
//
// Optional feature macro: READ_TIMEOUT_EN
//   defined   - READ_WAIT aborts to a two-cycle ERROR after TIMEOUT cycles
//   undefined - READ_WAIT waits indefinitely; no counter is built

module ahb_slave_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSELx,
    input  logic [1:0]        HTRANS,
    input  logic              addr_match,
    input  logic              m_write,
    input  logic              m_read,
    input  logic              data_ready,
    input  logic              invalid,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              rd_req,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        RD_DONE,
        ERR1,
        ERR2
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t decoded;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    logic accept;
    logic full;
    logic push;
    logic pop;
    logic timed_out;
    logic unused;

    // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY.
    assign unused = HTRANS[0];

    // full comes from the registered count, so a same-cycle pop cannot
    // release a stalled push; the push waits one more cycle.
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign wr_valid  = (count != '0);
    assign wr_data   = mem[rptr];
    assign push      = (state == WRITE) && !full;
    assign pop       = wr_valid && wr_ready;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    assign accept    = HSELx & HTRANS[1] & data_ready;

`ifdef READ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT) + 1;
    logic [TO_W-1:0] tcnt;

    assign timed_out = (tcnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (state_nxt == READ_WAIT && state != READ_WAIT) begin
            tcnt <= '0;
        end else if (state == READ_WAIT) begin
            tcnt <= tcnt + TO_W'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        decoded = IDLE;
        if (accept) begin
            if (invalid || !addr_match) begin
                decoded = ERR1;
            end else if (m_write) begin
                decoded = WRITE;
            end else if (m_read) begin
                decoded = READ_WAIT;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RD_DONE, ERR2: state_nxt = decoded;
            // A stalled write holds its data phase; the next address is
            // only sampled once this beat is pushed.
            WRITE:               if (!full) state_nxt = decoded;
            // rd_valid wins over a timeout landing in the same cycle.
            READ_WAIT: begin
                if (rd_valid) begin
                    state_nxt = RD_DONE;
                end else if (timed_out) begin
                    state_nxt = ERR1;
                end
            end
            ERR1:                state_nxt = ERR2;
            default:             state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            rd_req    <= 1'b0;
        end else begin
            state  <= state_nxt;
            HRESP  <= (state_nxt == ERR1) || (state_nxt == ERR2);
            rd_req <= (state_nxt == READ_WAIT) && (state != READ_WAIT);
            if (state_nxt == WRITE) begin
                HREADYOUT <= (count_nxt != CNT_W'(FIFO_DEPTH));
            end else begin
                HREADYOUT <= (state_nxt != READ_WAIT) && (state_nxt != ERR1);
            end
            if (state == READ_WAIT && rd_valid) begin
                HRDATA <= rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= HWDATA;
        end
    end

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// tb/tb_ahb_slave_ctrl.sv - directed self-checking bench for ahb_slave_ctrl

module tb_ahb_slave_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        HSELx;
    logic [1:0]  HTRANS;
    logic        addr_match;
    logic        m_write;
    logic        m_read;
    logic        data_ready;
    logic        invalid;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_valid;

    int tests_run = 0;
    int failed    = 0;

    ahb_slave_ctrl #(.FIFO_DEPTH(4), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .HSELx(HSELx), .HTRANS(HTRANS),
        .addr_match(addr_match), .m_write(m_write), .m_read(m_read),
        .data_ready(data_ready), .invalid(invalid), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic wr, input logic rd, input logic match, input logic inv);
        HSELx      = 1'b1;
        HTRANS     = 2'b10;
        m_write    = wr;
        m_read     = rd;
        addr_match = match;
        invalid    = inv;
    endtask

    task automatic idle_bus();
        HSELx      = 1'b0;
        HTRANS     = 2'b00;
        m_write    = 1'b0;
        m_read     = 1'b0;
        addr_match = 1'b0;
        invalid    = 1'b0;
    endtask

    task automatic drain_fifo();
        wr_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        wr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        data_ready = 1'b1;
        HWDATA = '0; wr_ready = 1'b0; rd_data = '0; rd_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tests_run++;
        if ({HREADYOUT, HRESP, wr_valid, rd_req} !== 4'b1000) begin
            failed++;
            $display("FAIL reset_ctrl got=%b exp=1000", {HREADYOUT, HRESP, wr_valid, rd_req});
        end
        tests_run++;
        if (HRDATA !== 32'h0) begin failed++; $display("FAIL reset_hrdata got=%h exp=0", HRDATA); end
    endtask

    task automatic test_single_write();
        set_addr(1, 0, 1, 0);
        tick();
        idle_bus();
        HWDATA = 32'hDEADBEEF;
        tests_run++;
        if (HREADYOUT !== 1'b1) begin failed++; $display("FAIL wr_dphase_ready got=%b exp=1", HREADYOUT); end
        tick();
        tests_run++;
        if (wr_valid !== 1'b1 || wr_data !== 32'hDEADBEEF) begin
            failed++;
            $display("FAIL wr_fifo_head got=%b/%h exp=1/deadbeef", wr_valid, wr_data);
        end
        tick();
        tests_run++;
        if (wr_data !== 32'hDEADBEEF) begin failed++; $display("FAIL wr_head_stable got=%h exp=deadbeef", wr_data); end
        drain_fifo();
        tests_run++;
        if (wr_valid !== 1'b0) begin failed++; $display("FAIL wr_drained got=%b exp=0", wr_valid); end
    endtask

    task automatic test_fifo_full();
        logic [31:0] words [5];
        words[0] = 32'h1111_0001; words[1] = 32'h2222_0002; words[2] = 32'h3333_0003;
        words[3] = 32'h4444_0004; words[4] = 32'h5555_0005;
        wr_ready = 1'b0;
        set_addr(1, 0, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            HWDATA = words[i];
            tests_run++;
            if (HREADYOUT !== 1'b1) begin failed++; $display("FAIL full_beat%0d_ready got=%b exp=1", i, HREADYOUT); end
            tick();
        end
        idle_bus();
        HWDATA = words[4];
        tests_run++;
        if (HREADYOUT !== 1'b0) begin failed++; $display("FAIL full_stall got=%b exp=0", HREADYOUT); end
        tests_run++;
        if (wr_data !== words[0]) begin failed++; $display("FAIL full_head got=%h exp=%h", wr_data, words[0]); end
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        tests_run++;
        if (HREADYOUT !== 1'b1) begin failed++; $display("FAIL full_unstall got=%b exp=1", HREADYOUT); end
        tick();
        tests_run++;
        if (HREADYOUT !== 1'b1) begin failed++; $display("FAIL full_after_idle got=%b exp=1", HREADYOUT); end
        wr_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            tests_run++;
            if (wr_valid !== 1'b1 || wr_data !== words[j]) begin
                failed++;
                $display("FAIL full_pop%0d got=%b/%h exp=1/%h", j, wr_valid, wr_data, words[j]);
            end
            tick();
        end
        wr_ready = 1'b0;
        tests_run++;
        if (wr_valid !== 1'b0) begin failed++; $display("FAIL full_empty got=%b exp=0", wr_valid); end
    endtask

    task automatic test_read_latency();
        int lows = 0;
        int reqs = 0;
        set_addr(0, 1, 1, 0);
        tick();
        idle_bus();
        for (int c = 1; c <= 4; c++) begin
            if (HREADYOUT === 1'b0) lows++;
            if (rd_req === 1'b1) reqs++;
            if (c == 4) begin
                rd_valid = 1'b1;
                rd_data  = 32'h12345678;
            end
            tick();
        end
        rd_valid = 1'b0;
        rd_data  = 32'hFFFF_0000;
        tests_run++;
        if (lows != 4 || reqs != 1) begin failed++; $display("FAIL rd_wait lows=%0d reqs=%0d exp=4/1", lows, reqs); end
        tests_run++;
        if ({HREADYOUT, HRESP, rd_req} !== 3'b100 || HRDATA !== 32'h12345678) begin
            failed++;
            $display("FAIL rd_done got=%b/%h exp=100/12345678", {HREADYOUT, HRESP, rd_req}, HRDATA);
        end
        rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        tests_run++;
        if (HRDATA !== 32'h12345678) begin failed++; $display("FAIL rd_stray_valid got=%h exp=12345678", HRDATA); end
    endtask

    task automatic test_read_min();
        set_addr(0, 1, 1, 0);
        tick();
        idle_bus();
        rd_valid = 1'b1;
        rd_data  = 32'hA5A5_5A5A;
        tests_run++;
        if (rd_req !== 1'b1 || HREADYOUT !== 1'b0) begin
            failed++;
            $display("FAIL rd_min_first got=%b%b exp=10", rd_req, HREADYOUT);
        end
        tick();
        rd_valid = 1'b0;
        tests_run++;
        if (HREADYOUT !== 1'b1 || HRDATA !== 32'hA5A5_5A5A || rd_req !== 1'b0) begin
            failed++;
            $display("FAIL rd_min_done got=%b/%h/%b exp=1/a5a55a5a/0", HREADYOUT, HRDATA, rd_req);
        end
    endtask

    task automatic test_error();
        set_addr(1, 0, 1, 1);
        tick();
        idle_bus();
        tests_run++;
        if ({HREADYOUT, HRESP, rd_req, wr_valid} !== 4'b0100) begin
            failed++;
            $display("FAIL err1 got=%b exp=0100", {HREADYOUT, HRESP, rd_req, wr_valid});
        end
        tick();
        tests_run++;
        if ({HREADYOUT, HRESP, wr_valid} !== 3'b110) begin
            failed++;
            $display("FAIL err2 got=%b exp=110", {HREADYOUT, HRESP, wr_valid});
        end
        set_addr(1, 0, 1, 0);
        tick();
        idle_bus();
        HWDATA = 32'hCAFEF00D;
        tests_run++;
        if ({HREADYOUT, HRESP} !== 2'b10) begin failed++; $display("FAIL err_then_write got=%b exp=10", {HREADYOUT, HRESP}); end
        tick();
        tests_run++;
        if (wr_valid !== 1'b1 || wr_data !== 32'hCAFEF00D) begin
            failed++;
            $display("FAIL err_write_push got=%b/%h exp=1/cafef00d", wr_valid, wr_data);
        end
        drain_fifo();
        set_addr(0, 1, 0, 0);
        tick();
        idle_bus();
        tests_run++;
        if ({HREADYOUT, HRESP, rd_req} !== 3'b010) begin
            failed++;
            $display("FAIL err_nomatch got=%b exp=010", {HREADYOUT, HRESP, rd_req});
        end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        set_addr(1, 0, 1, 0);
        tick();
        HWDATA = 32'h0BAD_F00D;
        set_addr(0, 1, 1, 0);
        tick();
        idle_bus();
        rd_valid = 1'b1;
        rd_data  = 32'h7777_8888;
        tests_run++;
        if (rd_req !== 1'b1 || HREADYOUT !== 1'b0 || wr_data !== 32'h0BAD_F00D) begin
            failed++;
            $display("FAIL b2b_read got=%b%b/%h exp=10/0badf00d", rd_req, HREADYOUT, wr_data);
        end
        tick();
        rd_valid = 1'b0;
        tests_run++;
        if (HREADYOUT !== 1'b1 || HRDATA !== 32'h7777_8888) begin
            failed++;
            $display("FAIL b2b_done got=%b/%h exp=1/77778888", HREADYOUT, HRDATA);
        end
    endtask

    task automatic test_reset_mid_read();
        set_addr(0, 1, 1, 0);
        tick();
        idle_bus();
        tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tests_run++;
        if ({HREADYOUT, HRESP, wr_valid, rd_req} !== 4'b1000 || HRDATA !== 32'h0) begin
            failed++;
            $display("FAIL reset_mid_read got=%b/%h exp=1000/0", {HREADYOUT, HRESP, wr_valid, rd_req}, HRDATA);
        end
        tick();
        tests_run++;
        if ({HREADYOUT, rd_req} !== 2'b10) begin failed++; $display("FAIL reset_stays_idle got=%b exp=10", {HREADYOUT, rd_req}); end
    endtask

`ifdef READ_TIMEOUT_EN
    task automatic test_timeout();
        int lows = 0;
        set_addr(0, 1, 1, 0);
        tick();
        idle_bus();
        for (int c = 1; c <= 16; c++) begin
            if (HREADYOUT === 1'b0 && HRESP === 1'b0) lows++;
            tick();
        end
        tests_run++;
        if (lows != 16) begin failed++; $display("FAIL to_wait got=%0d exp=16", lows); end
        tests_run++;
        if ({HREADYOUT, HRESP} !== 2'b01) begin failed++; $display("FAIL to_err1 got=%b exp=01", {HREADYOUT, HRESP}); end
        tick();
        tests_run++;
        if ({HREADYOUT, HRESP} !== 2'b11) begin failed++; $display("FAIL to_err2 got=%b exp=11", {HREADYOUT, HRESP}); end
        tick();
        rd_valid = 1'b1;
        rd_data  = 32'hBBBB_CCCC;
        tick();
        rd_valid = 1'b0;
        tests_run++;
        if (HRDATA !== 32'h0 || HREADYOUT !== 1'b1) begin
            failed++;
            $display("FAIL to_late_valid got=%h/%b exp=0/1", HRDATA, HREADYOUT);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_fifo_full();
        test_read_latency();
        test_read_min();
        test_error();
        test_back_to_back();
        drain_fifo();
        test_reset_mid_read();
`ifdef READ_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
